// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master native memory bus arbiter.
// Grant encodings double as the one-hot grant output value.
package mem_bus_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Ties go to m0 under fixed priority, otherwise to whoever did not win last time.
  function automatic logic [1:0] pickWinner(input logic req0, input logic req1,
                                            input logic [1:0] lastGrant,
                                            input logic fixedPrio);
    if (req0 && !req1) return GNT_M0;
    if (req1 && !req0) return GNT_M1;
    if (!req0) return GNT_NONE;
    if (fixedPrio || (lastGrant == GNT_M1)) return GNT_M0;
    return GNT_M1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// picorv32-style native memory bus: master drives the request, slave answers.
interface mem_bus_arbiter_if;

  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, output addr, output wdata, output wstrb,
                  input ready, input rdata);

  modport slave (input valid, input addr, input wdata, input wstrb,
                 output ready, output rdata);

endinterface

// File: rtl/mem_arb_timer.sv
// Bus watchdog counter: cleared when a transaction starts, counts stalled BUSY cycles.
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] count_q, count_d;

  // Saturates at the limit so a lingering enable can never wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (TIMEOUT != 0) && (count_q == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave arbiter for the native memory bus, with a grant held
// per transaction, a forced IDLE turnaround and a hung-slave watchdog.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int          FIXED_PRIO   = 0,
  parameter int          TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = DEFAULT_TIMEOUT_DATA
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_arbiter_if.slave   m0,
  mem_bus_arbiter_if.slave   m1,
  mem_bus_arbiter_if.master  s,
  output logic [1:0]         grant_o,
  output logic               busy_o,
  output logic               err_o
);

  logic [0:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  lastGrant_q, lastGrant_d;
  logic [1:0]  winner;
  logic        busyNow;
  logic        startTx;
  logic        timerExpire;
  logic        timeoutHit;
  logic        done;
  logic        gValid;
  logic [31:0] gAddr;
  logic [31:0] gWdata;
  logic [3:0]  gWstrb;

  always_comb begin
    gValid = 1'b0;
    gAddr  = '0;
    gWdata = '0;
    gWstrb = '0;
    case (grant_q)
      GNT_M0: begin
        gValid = m0.valid;
        gAddr  = m0.addr;
        gWdata = m0.wdata;
        gWstrb = m0.wstrb;
      end
      GNT_M1: begin
        gValid = m1.valid;
        gAddr  = m1.addr;
        gWdata = m1.wdata;
        gWstrb = m1.wstrb;
      end
      default: ;
    endcase
  end

  assign busyNow    = (state_q == ST_BUSY);
  assign startTx    = (state_q == ST_IDLE) && (m0.valid || m1.valid);
  assign winner     = pickWinner(m0.valid, m1.valid, lastGrant_q, FIXED_PRIO != 0);
  // A real s_ready on the expiry cycle takes precedence over the forced completion.
  assign timeoutHit = busyNow && gValid && !s.ready && timerExpire;
  assign done       = busyNow && (s.ready || timeoutHit);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    case (state_q)
      ST_IDLE: begin
        if (startTx) begin
          state_d     = ST_BUSY;
          grant_d     = winner;
          lastGrant_d = winner;
        end
      end
      default: begin
        if (done || !gValid) begin
          state_d = ST_IDLE;
          grant_d = GNT_NONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= GNT_NONE;
      lastGrant_q <= GNT_M1;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (startTx),
    .enable_i (busyNow && !s.ready),
    .expire_o (timerExpire)
  );

  assign s.valid = busyNow;
  assign s.addr  = gAddr;
  assign s.wdata = gWdata;
  assign s.wstrb = busyNow ? gWstrb : 4'b0000;

  assign m0.ready = done && (grant_q == GNT_M0);
  assign m1.ready = done && (grant_q == GNT_M1);
  assign m0.rdata = (timeoutHit && (grant_q == GNT_M0)) ? TIMEOUT_DATA : s.rdata;
  assign m1.rdata = (timeoutHit && (grant_q == GNT_M1)) ? TIMEOUT_DATA : s.rdata;

  assign grant_o = grant_q;
  assign busy_o  = busyNow;
  assign err_o   = timeoutHit;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical master traffic
// and compares both against a transaction-level model every cycle.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int          TO = 8;
  localparam logic [31:0] TD = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        m0Ready;
    logic        m1Ready;
    logic [31:0] m0Rdata;
    logic [31:0] m1Rdata;
    logic        sValid;
    logic [31:0] sAddr;
    logic [31:0] sWdata;
    logic [3:0]  sWstrb;
    logic [1:0]  grant;
    logic        busy;
    logic        err;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0Valid, m1Valid, sReady;
  logic [31:0] m0Addr, m0Wdata, m1Addr, m1Wdata, sRdata;
  logic [3:0]  m0Wstrb, m1Wstrb;
  logic [1:0]  grantA, grantB;
  logic        busyA, busyB, errA, errB;
  obs_t        obsA, obsB;

  always #5 clk = ~clk;

  mem_bus_arbiter_if m0A ();
  mem_bus_arbiter_if m1A ();
  mem_bus_arbiter_if sA ();
  mem_bus_arbiter_if m0B ();
  mem_bus_arbiter_if m1B ();
  mem_bus_arbiter_if sB ();

  assign m0A.valid = m0Valid;
  assign m0A.addr  = m0Addr;
  assign m0A.wdata = m0Wdata;
  assign m0A.wstrb = m0Wstrb;
  assign m1A.valid = m1Valid;
  assign m1A.addr  = m1Addr;
  assign m1A.wdata = m1Wdata;
  assign m1A.wstrb = m1Wstrb;
  assign sA.ready  = sReady;
  assign sA.rdata  = sRdata;
  assign m0B.valid = m0Valid;
  assign m0B.addr  = m0Addr;
  assign m0B.wdata = m0Wdata;
  assign m0B.wstrb = m0Wstrb;
  assign m1B.valid = m1Valid;
  assign m1B.addr  = m1Addr;
  assign m1B.wdata = m1Wdata;
  assign m1B.wstrb = m1Wstrb;
  assign sB.ready  = sReady;
  assign sB.rdata  = sRdata;

  mem_bus_arbiter #(
    .FIXED_PRIO (0),
    .TIMEOUT    (TO)
  ) dutA (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0A),
    .m1      (m1A),
    .s       (sA),
    .grant_o (grantA),
    .busy_o  (busyA),
    .err_o   (errA)
  );

  mem_bus_arbiter #(
    .FIXED_PRIO (1),
    .TIMEOUT    (TO)
  ) dutB (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0B),
    .m1      (m1B),
    .s       (sB),
    .grant_o (grantB),
    .busy_o  (busyB),
    .err_o   (errB)
  );

  assign obsA = {m0A.ready, m1A.ready, m0A.rdata, m1A.rdata, sA.valid, sA.addr,
                 sA.wdata, sA.wstrb, grantA, busyA, errA};
  assign obsB = {m0B.ready, m1B.ready, m0B.rdata, m1B.rdata, sB.valid, sB.addr,
                 sB.wdata, sB.wstrb, grantB, busyB, errB};

  int   testsRun = 0;
  int   testsFailed = 0;
  // Model state per DUT: owner 0 = nobody, 1 = m0, 2 = m1; waitCycles = BUSY cycles elapsed.
  int   ownerM[2];
  int   lastM[2];
  int   waitM[2];
  obs_t lastObs[2];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit v0, input bit v1, input bit sr, input bit rs,
                               input logic [31:0] rd);
    rst     = rs;
    m0Valid = v0;
    m1Valid = v1;
    sReady  = sr;
    sRdata  = rd;
    m0Addr  = $urandom;
    m0Wdata = $urandom;
    m0Wstrb = 4'($urandom);
    m1Addr  = $urandom;
    m1Wdata = $urandom;
    m1Wstrb = 4'($urandom);
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      ownerM[d] = 0;
      lastM[d]  = 2;
      waitM[d]  = 0;
    end
  endtask

  // Compare one DUT against the model for the current cycle, then advance the model.
  task automatic checkDut(input int d, input bit fixedPrio);
    obs_t        o;
    string       n;
    bit          busy, gv, tHit, done;
    logic [31:0] gAddr, gWdata, expRdata;
    logic [3:0]  gStrb;
    logic [1:0]  expGrant;
    int          w;
    o = (d == 0) ? obsA : obsB;
    n = (d == 0) ? "A" : "B";
    busy = (ownerM[d] != 0);
    gv = 1'b0;
    gAddr = '0;
    gWdata = '0;
    gStrb = '0;
    if (ownerM[d] == 1) begin
      gv = m0Valid; gAddr = m0Addr; gWdata = m0Wdata; gStrb = m0Wstrb;
    end else if (ownerM[d] == 2) begin
      gv = m1Valid; gAddr = m1Addr; gWdata = m1Wdata; gStrb = m1Wstrb;
    end
    expGrant = (ownerM[d] == 1) ? 2'b01 : (ownerM[d] == 2) ? 2'b10 : 2'b00;
    tHit = busy && gv && !sReady && (waitM[d] == TO);
    done = busy && (sReady || tHit);

    checkOutput({n, ".grant"}, 32'(o.grant), 32'(expGrant));
    checkOutput({n, ".busy"}, 32'(o.busy), 32'(busy));
    checkOutput({n, ".sValid"}, 32'(o.sValid), 32'(busy));
    checkOutput({n, ".sWstrb"}, 32'(o.sWstrb), busy ? 32'(gStrb) : 32'd0);
    checkOutput({n, ".err"}, 32'(o.err), 32'(tHit));
    checkOutput({n, ".m0Ready"}, 32'(o.m0Ready), 32'(done && ownerM[d] == 1));
    checkOutput({n, ".m1Ready"}, 32'(o.m1Ready), 32'(done && ownerM[d] == 2));
    expRdata = (tHit && ownerM[d] == 1) ? TD : sRdata;
    checkOutput({n, ".m0Rdata"}, o.m0Rdata, expRdata);
    expRdata = (tHit && ownerM[d] == 2) ? TD : sRdata;
    checkOutput({n, ".m1Rdata"}, o.m1Rdata, expRdata);
    if (busy) begin
      checkOutput({n, ".sAddr"}, o.sAddr, gAddr);
      checkOutput({n, ".sWdata"}, o.sWdata, gWdata);
    end
    lastObs[d] = o;

    if (rst) begin
      ownerM[d] = 0;
      lastM[d]  = 2;
      waitM[d]  = 0;
    end else if (!busy) begin
      if (m0Valid || m1Valid) begin
        if (m0Valid && m1Valid) w = (fixedPrio || lastM[d] == 2) ? 1 : 2;
        else w = m0Valid ? 1 : 2;
        ownerM[d] = w;
        lastM[d]  = w;
        waitM[d]  = 0;
      end
    end else if (done || !gv) begin
      ownerM[d] = 0;
    end else begin
      waitM[d]++;
    end
  endtask

  task automatic stepCycle(input bit v0, input bit v1, input bit sr, input bit rs,
                           input logic [31:0] rd);
    @(negedge clk);
    applyStimulus(v0, v1, sr, rs, rd);
    #1;
    checkDut(0, 1'b0);
    checkDut(1, 1'b1);
  endtask

  initial begin
    int m0GrantsA, m1GrantsA, m1GrantsB, errAt;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    repeat (2) @(posedge clk);
    modelReset();

    // Reset state and idle behaviour
    stepCycle(1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    stepCycle(1'b0, 1'b0, 1'b1, 1'b0, $urandom);

    // Single m0 read against a combinational slave
    stepCycle(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    stepCycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
    checkOutput("m0ReadReady", 32'(lastObs[0].m0Ready), 32'd1);
    checkOutput("m0ReadData", lastObs[0].m0Rdata, 32'h1234_5678);
    stepCycle(1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    checkOutput("turnaroundValid", 32'(lastObs[0].sValid), 32'd0);
    checkOutput("turnaroundGrant", 32'(lastObs[0].grant), 32'd0);

    // Both masters requesting continuously for eight transactions
    m0GrantsA = 0;
    m1GrantsA = 0;
    m1GrantsB = 0;
    for (int i = 0; i < 8; i++) begin
      stepCycle(1'b1, 1'b1, 1'b0, 1'b0, $urandom);
      stepCycle(1'b1, 1'b1, 1'b1, 1'b0, $urandom);
      if (lastObs[0].grant == 2'b01) m0GrantsA++;
      if (lastObs[0].grant == 2'b10) m1GrantsA++;
      if (lastObs[1].grant == 2'b10) m1GrantsB++;
    end
    checkOutput("rrM0Grants", 32'(m0GrantsA), 32'd4);
    checkOutput("rrM1Grants", 32'(m1GrantsA), 32'd4);
    checkOutput("fixedM1Grants", 32'(m1GrantsB), 32'd0);
    stepCycle(1'b0, 1'b1, 1'b0, 1'b0, $urandom);
    stepCycle(1'b0, 1'b1, 1'b1, 1'b0, $urandom);
    checkOutput("fixedM1AfterDrop", 32'(lastObs[1].grant), 32'(2'b10));
    stepCycle(1'b0, 1'b0, 1'b0, 1'b0, $urandom);

    // m1 write to a slave that never answers
    stepCycle(1'b0, 1'b1, 1'b0, 1'b0, $urandom);
    errAt = -1;
    for (int k = 0; k < 12; k++) begin
      stepCycle(1'b0, 1'b1, 1'b0, 1'b0, $urandom);
      if (errAt < 0 && lastObs[0].err === 1'b1) errAt = k;
    end
    checkOutput("timeoutCycle", 32'(errAt), 32'(TO));
    stepCycle(1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    stepCycle(1'b0, 1'b0, 1'b0, 1'b0, $urandom);

    // s_ready arriving exactly on the expiry cycle
    stepCycle(1'b0, 1'b1, 1'b0, 1'b0, $urandom);
    for (int k = 0; k <= TO; k++) begin
      stepCycle(1'b0, 1'b1, k == TO, 1'b0, 32'hCAFE_F00D);
    end
    checkOutput("raceErr", 32'(lastObs[0].err), 32'd0);
    checkOutput("raceReady", 32'(lastObs[0].m1Ready), 32'd1);
    checkOutput("raceData", lastObs[0].m1Rdata, 32'hCAFE_F00D);
    stepCycle(1'b0, 1'b0, 1'b0, 1'b0, $urandom);

    // Reset two cycles into a stalled transaction
    stepCycle(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    stepCycle(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    stepCycle(1'b1, 1'b0, 1'b0, 1'b1, $urandom);
    stepCycle(1'b1, 1'b1, 1'b0, 1'b0, $urandom);
    checkOutput("rstValid", 32'(lastObs[0].sValid), 32'd0);
    checkOutput("rstGrant", 32'(lastObs[0].grant), 32'd0);
    checkOutput("rstReady", 32'(lastObs[0].m0Ready | lastObs[0].m1Ready), 32'd0);
    stepCycle(1'b1, 1'b1, 1'b1, 1'b0, $urandom);
    checkOutput("postRstTie", 32'(lastObs[0].grant), 32'(2'b01));
    stepCycle(1'b0, 1'b0, 1'b0, 1'b0, $urandom);

    // Random traffic: aborts, ties, slow slaves, timeouts and occasional resets
    for (int i = 0; i < 2000; i++) begin
      stepCycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) < 2, $urandom_range(0, 199) == 0, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
